// File: rtl/dsp_dac_interface.sv
// dsp_dac_interface
// Output-side buffer between the FIR engine and a DAC. Samples arrive on a
// valid/ready push port and are queued in a small single-clock FIFO. An
// internal rate divider plays them out to the DAC. Playout waits until the
// FIFO holds PRIME_LEVEL samples. If the FIFO runs dry, the last code is
// repeated, underrun is flagged and the FIFO is primed again.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clk_en            clock enable; 0 freezes all state and masks dac_strobe
//   enable            playout enable
//   flush             synchronous FIFO clear
//   rate_div          DAC period minus 1, in clk cycles
//   dsp_data_in       sample from the FIR engine
//   dsp_valid_in      sample valid
//   dsp_ready_out     FIFO can accept a sample
//   dac_data_out      registered DAC code
//   dac_strobe        one-cycle DAC update pulse
//   fifo_level        FIFO occupancy
//   fifo_empty        FIFO empty
//   fifo_full         FIFO full
//   underrun          sticky: a playout tick found the FIFO empty
//   overflow          sticky: a valid sample was dropped while full
//   status_clr        clears underrun and overflow
module dsp_dac_interface #(
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_WIDTH   = 8,
    parameter int PRIME_LEVEL = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clk_en,
    input  logic                          enable,
    input  logic                          flush,
    input  logic [DIV_WIDTH-1:0]          rate_div,
    input  logic [DATA_WIDTH-1:0]         dsp_data_in,
    input  logic                          dsp_valid_in,
    output logic                          dsp_ready_out,
    output logic [DATA_WIDTH-1:0]         dac_data_out,
    output logic                          dac_strobe,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic                          underrun,
    output logic                          overflow,
    input  logic                          status_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t                state, state_nxt;
    logic [PTR_W:0]        wr_ptr, rd_ptr;   // MSB is the wrap bit
    logic [LVL_W-1:0]      level;
    logic [DIV_WIDTH-1:0]  cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  strobe_q;

    logic push, pop, tick, run_active, prime_ok;

    assign fifo_level    = level;
    assign fifo_empty    = (level == '0);
    assign fifo_full     = (level == LVL_W'(FIFO_DEPTH));
    assign dsp_ready_out = !fifo_full;
    // The strobe register holds while frozen; the output is masked instead.
    assign dac_strobe    = strobe_q && clk_en;

    // A push during flush is discarded along with the FIFO contents.
    assign push       = dsp_valid_in && !fifo_full && !flush;
    // Dropping enable (or flushing) suppresses the tick in that same cycle.
    assign run_active = (state == RUN) && enable && !flush;
    assign tick       = run_active && (cnt >= rate_div);
    // Empty comes from the registered level, so a same-cycle push into an
    // empty FIFO is not visible to the pop (no fall-through).
    assign pop        = tick && !fifo_empty;
    assign prime_ok   = (level >= LVL_W'(PRIME_LEVEL));

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = enable ? PRIME : IDLE;
        end else begin
            case (state)
                IDLE:    if (enable) state_nxt = PRIME;
                PRIME: begin
                    if (!enable)       state_nxt = IDLE;
                    else if (prime_ok) state_nxt = RUN;
                end
                RUN: begin
                    if (!enable)                 state_nxt = IDLE;
                    else if (tick && fifo_empty) state_nxt = PRIME;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Counter runs only while actively playing; held at 0 otherwise so the
    // first tick after entering RUN lands on RUN cycle rate_div.
    always_comb begin
        cnt_nxt = '0;
        if (run_active && !tick) cnt_nxt = cnt + DIV_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst && clk_en && push) mem[wr_ptr[PTR_W-1:0]] <= dsp_data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            cnt          <= '0;
            dac_data_out <= '0;
            strobe_q     <= 1'b0;
            underrun     <= 1'b0;
            overflow     <= 1'b0;
        end else if (clk_en) begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            strobe_q <= tick;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
                if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
                case ({push, pop})
                    2'b10:   level <= level + LVL_W'(1);
                    2'b01:   level <= level - LVL_W'(1);
                    default: level <= level;
                endcase
            end

            // On an empty tick the old code stays and is strobed again.
            if (pop) dac_data_out <= mem[rd_ptr[PTR_W-1:0]];

            // Setting wins over a simultaneous clear.
            if (dsp_valid_in && fifo_full) overflow <= 1'b1;
            else if (status_clr)           overflow <= 1'b0;

            if (tick && fifo_empty)  underrun <= 1'b1;
            else if (status_clr)     underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dsp_dac_interface.sv
// Directed self-checking bench for dsp_dac_interface (default parameters).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_dsp_dac_interface;

    logic        clk = 1'b0;
    logic        rst, clk_en, enable, flush, dsp_valid_in, status_clr;
    logic [7:0]  rate_div;
    logic [15:0] dsp_data_in;
    logic        dsp_ready_out, dac_strobe, fifo_empty, fifo_full, underrun, overflow;
    logic [15:0] dac_data_out;
    logic [3:0]  fifo_level;

    int checks = 0;
    int failures = 0;
    int w;

    always #5 clk = ~clk;

    dsp_dac_interface dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .enable       (enable),
        .flush        (flush),
        .rate_div     (rate_div),
        .dsp_data_in  (dsp_data_in),
        .dsp_valid_in (dsp_valid_in),
        .dsp_ready_out(dsp_ready_out),
        .dac_data_out (dac_data_out),
        .dac_strobe   (dac_strobe),
        .fifo_level   (fifo_level),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .underrun     (underrun),
        .overflow     (overflow),
        .status_clr   (status_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Steps until dac_strobe is seen (or max_cyc cycles pass); returns cycles waited.
    task automatic wait_strobe(input int max_cyc, output int waited);
        waited = 0;
        while (!dac_strobe && waited < max_cyc) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic push_seq(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            dsp_data_in  = base + 16'(i);
            dsp_valid_in = 1'b1;
            step(1);
        end
        dsp_valid_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; enable = 1'b0; flush = 1'b0;
        dsp_valid_in = 1'b0; status_clr = 1'b0; rate_div = 8'd0; dsp_data_in = '0;
        step(2);
        rst = 1'b0;

        // 1. reset mid-traffic
        push_seq(16'hAAAA, 2);
        chk("pre_rst_level", 32'(fifo_level), 32'd2);
        enable = 1'b1;
        rst = 1'b1;
        step(2);
        rst = 1'b0; enable = 1'b0;
        chk("rst_data",     32'(dac_data_out), 32'h0);
        chk("rst_strobe",   32'(dac_strobe),   32'd0);
        chk("rst_level",    32'(fifo_level),   32'd0);
        chk("rst_empty",    32'(fifo_empty),   32'd1);
        chk("rst_full",     32'(fifo_full),    32'd0);
        chk("rst_ready",    32'(dsp_ready_out),32'd1);
        chk("rst_underrun", 32'(underrun),     32'd0);
        chk("rst_overflow", 32'(overflow),     32'd0);

        // 2. priming and rate (rate_div=3 -> period 4)
        rate_div = 8'd3; enable = 1'b1;
        push_seq(16'h0001, 4);
        chk("prime_level", 32'(fifo_level), 32'd4);
        wait_strobe(20, w);
        chk("first_latency", 32'(w), 32'd5);
        chk("play_1", 32'(dac_data_out), 32'h0001);
        for (int k = 2; k <= 4; k++) begin
            step(1);
            wait_strobe(20, w);
            chk("spacing", 32'(w), 32'd3);
            chk("play_n", 32'(dac_data_out), 32'(k));
        end
        chk("no_underrun_yet", 32'(underrun), 32'd0);

        // 3. underrun: fifth strobe repeats last code, then silence
        step(1);
        wait_strobe(20, w);
        chk("ur_spacing", 32'(w), 32'd3);
        chk("ur_repeat",  32'(dac_data_out), 32'h0004);
        chk("ur_flag",    32'(underrun), 32'd1);
        step(1);
        wait_strobe(12, w);
        chk("ur_silent", 32'(w), 32'd12);
        push_seq(16'h0011, 4);
        wait_strobe(20, w);
        chk("resume_latency", 32'(w), 32'd5);
        chk("resume_1", 32'(dac_data_out), 32'h0011);
        for (int k = 1; k < 4; k++) begin
            step(1);
            wait_strobe(20, w);
            chk("resume_spacing", 32'(w), 32'd3);
            chk("resume_n", 32'(dac_data_out), 32'h0011 + 32'(k));
        end

        // 4. overflow with playout disabled
        enable = 1'b0; status_clr = 1'b1;
        step(1);
        status_clr = 1'b0;
        chk("clr_alone_ur", 32'(underrun), 32'd0);
        chk("ovf_start_level", 32'(fifo_level), 32'd0);
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin
                chk("full_ready", 32'(dsp_ready_out), 32'd0);
                chk("full_flag",  32'(fifo_full),     32'd1);
                chk("full_level", 32'(fifo_level),    32'd8);
                chk("no_ovf_yet", 32'(overflow),      32'd0);
            end
            dsp_data_in  = 16'h0100 + 16'(i);
            dsp_valid_in = 1'b1;
            step(1);
        end
        dsp_valid_in = 1'b0;
        chk("ovf_flag",  32'(overflow),   32'd1);
        chk("ovf_level", 32'(fifo_level), 32'd8);
        rate_div = 8'd0; enable = 1'b1;
        wait_strobe(10, w);
        chk("fast_latency", 32'(w), 32'd3);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step(1);
            chk("fast_strobe", 32'(dac_strobe), 32'd1);
            chk("fast_data",   32'(dac_data_out), 32'h0100 + 32'(i));
        end
        step(1);
        chk("fast_ur_strobe", 32'(dac_strobe), 32'd1);
        chk("fast_ur_data",   32'(dac_data_out), 32'h0107);
        chk("fast_ur_flag",   32'(underrun), 32'd1);
        enable = 1'b0; status_clr = 1'b1;
        step(1);
        status_clr = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);

        // 5. push and pop on the same tick at level 3; clear vs set
        rate_div = 8'd7; enable = 1'b1;
        push_seq(16'h0200, 4);
        wait_strobe(30, w);
        chk("pp_first", 32'(dac_data_out), 32'h0200);
        chk("pp_level_a", 32'(fifo_level), 32'd3);
        step(7);
        chk("pp_level_b", 32'(fifo_level), 32'd3);
        dsp_data_in = 16'h02FF; dsp_valid_in = 1'b1;
        step(1);
        dsp_valid_in = 1'b0;
        chk("pp_strobe", 32'(dac_strobe), 32'd1);
        chk("pp_data",   32'(dac_data_out), 32'h0201);
        chk("pp_level",  32'(fifo_level), 32'd3);
        step(31);
        chk("pp_drained", 32'(fifo_empty), 32'd1);
        chk("pp_ur_before", 32'(underrun), 32'd0);
        status_clr = 1'b1;
        step(1);
        chk("set_wins_ur",     32'(underrun), 32'd1);
        chk("set_wins_strobe", 32'(dac_strobe), 32'd1);
        chk("set_wins_data",   32'(dac_data_out), 32'h02FF);
        step(1);
        status_clr = 1'b0;
        chk("clr_ur", 32'(underrun), 32'd0);
        chk("clr_ovf_stays", 32'(overflow), 32'd0);

        // 6. clk_en freeze in RUN (rate_div=2), then flush
        rate_div = 8'd2;
        push_seq(16'h0300, 6);
        wait_strobe(20, w);
        chk("ce_latency", 32'(w), 32'd2);
        chk("ce_first",   32'(dac_data_out), 32'h0300);
        step(1);
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("ce_frozen_strobe", 32'(dac_strobe), 32'd0);
        end
        chk("ce_frozen_data", 32'(dac_data_out), 32'h0300);
        clk_en = 1'b1;
        wait_strobe(10, w);
        chk("ce_resume", 32'(w), 32'd2);
        chk("ce_data",   32'(dac_data_out), 32'h0301);
        chk("ce_level",  32'(fifo_level), 32'd4);
        enable = 1'b0;
        step(1);
        push_seq(16'h0306, 1);
        chk("fl_level_pre", 32'(fifo_level), 32'd5);
        flush = 1'b1; enable = 1'b1;
        dsp_data_in = 16'hDEAD; dsp_valid_in = 1'b1;
        step(1);
        flush = 1'b0; dsp_valid_in = 1'b0;
        chk("fl_level", 32'(fifo_level), 32'd0);
        chk("fl_empty", 32'(fifo_empty), 32'd1);
        chk("fl_data",  32'(dac_data_out), 32'h0301);
        step(3);
        chk("fl_hold_level", 32'(fifo_level), 32'd0);
        chk("fl_no_strobe",  32'(dac_strobe), 32'd0);
        push_seq(16'h0400, 4);
        wait_strobe(20, w);
        chk("fl_reprime_lat",  32'(w), 32'd4);
        chk("fl_reprime_data", 32'(dac_data_out), 32'h0400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
